// File: rtl/demux1_4_dispatch_if.sv
// Handshake bundle between the shared producer, the 1:4 dispatcher and its four consumers.
// slave = dispatcher side, master = producer/consumer (environment) side.
interface demux1_4_dispatch_if #(
    parameter int DW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_sel;
    logic [DW-1:0] in_data;
    logic [DW-1:0] q0;
    logic [DW-1:0] q1;
    logic [DW-1:0] q2;
    logic [DW-1:0] q3;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, q0, q1, q2, q3, out_valid
    );

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, q0, q1, q2, q3, out_valid
    );
endinterface

// File: rtl/demux1_4_dispatch.sv
// 1:4 dispatcher: routes one word per input handshake into one of four one-entry output channels.
// Optional macro DEMUX1_4_DISPATCH_CNT_EN adds per-channel saturating delivery counters.
module demux1_4_dispatch #(
    parameter int DW = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    demux1_4_dispatch_if.slave      bus
`ifdef DEMUX1_4_DISPATCH_CNT_EN
    ,
    input  logic                    cnt_clr,
    output logic [31:0]             dlv_cnt
`endif
);

    logic [1:0]    ch;
    logic          ready;
    logic [3:0]    load;
    logic [3:0]    drain;
    logic [3:0]    valid_q;
    logic [3:0]    valid_d;
    logic [DW-1:0] data_q [4];
    logic [DW-1:0] data_d [4];

    // Channel map mirrors the 4:1 selector encoding: sel is the bitwise inverse of the channel index.
    always_comb begin
        ch = 2'd0;
        case (bus.in_sel)
            2'b00:   ch = 2'd3;
            2'b01:   ch = 2'd2;
            2'b10:   ch = 2'd1;
            2'b11:   ch = 2'd0;
            default: ch = 2'd0;
        endcase
    end

    always_comb begin
        ready   = ~valid_q[ch] | bus.out_ready[ch];
        load    = 4'b0000;
        if (bus.in_valid && ready) begin
            load[ch] = 1'b1;
        end
        drain   = valid_q & bus.out_ready;
        valid_d = (valid_q & ~drain) | load;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = load[k] ? bus.in_data : data_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.q0        = data_q[0];
    assign bus.q1        = data_q[1];
    assign bus.q2        = data_q[2];
    assign bus.q3        = data_q[3];

`ifdef DEMUX1_4_DISPATCH_CNT_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    // Clear wins over a same-cycle delivery; counters stick at 8'hFF.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            cnt_d[j] = cnt_q[j];
            if (cnt_clr) begin
                cnt_d[j] = 8'h00;
            end else if (drain[j] && (cnt_q[j] != 8'hFF)) begin
                cnt_d[j] = cnt_q[j] + 8'h01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) begin
                cnt_q[j] <= 8'h00;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                cnt_q[j] <= cnt_d[j];
            end
        end
    end

    assign dlv_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux1_4_dispatch.sv
// Directed self-checking bench for demux1_4_dispatch; counter checks are built only with DEMUX1_4_DISPATCH_CNT_EN.
module tb_demux1_4_dispatch;

    localparam int DW = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    demux1_4_dispatch_if #(.DW(DW)) bus ();

`ifdef DEMUX1_4_DISPATCH_CNT_EN
    logic        cnt_clr;
    logic [31:0] dlv_cnt;
`endif

    demux1_4_dispatch #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
`ifdef DEMUX1_4_DISPATCH_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .dlv_cnt (dlv_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, then settle so combinational in_ready can be sampled.
    task automatic drive(input logic v, input logic [1:0] sel, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_data  = d;
        #1;
    endtask

    task automatic next_half;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
`ifdef DEMUX1_4_DISPATCH_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", {28'd0, bus.out_valid}, 32'h0);
        check("rst_q0", {30'd0, bus.q0}, 32'h0);
        check("rst_q3", {30'd0, bus.q3}, 32'h0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'h1);
`ifdef DEMUX1_4_DISPATCH_CNT_EN
        check("rst_dlv_cnt", dlv_cnt, 32'h0);
`endif
        next_half();
        rst_n = 1'b1;

        // Map check with all consumers ready
        bus.out_ready = 4'b1111;
        next_half();
        drive(1'b1, 2'b00, 2'd1);
        check("map_rdy0", {31'd0, bus.in_ready}, 32'h1);
        next_half();
        check("map_v3", {28'd0, bus.out_valid}, 32'h8);
        check("map_q3", {30'd0, bus.q3}, 32'h1);
        drive(1'b1, 2'b01, 2'd2);
        next_half();
        check("map_v2", {28'd0, bus.out_valid}, 32'h4);
        check("map_q2", {30'd0, bus.q2}, 32'h2);
        drive(1'b1, 2'b10, 2'd3);
        next_half();
        check("map_v1", {28'd0, bus.out_valid}, 32'h2);
        check("map_q1", {30'd0, bus.q1}, 32'h3);
        drive(1'b1, 2'b11, 2'd0);
        next_half();
        check("map_v0", {28'd0, bus.out_valid}, 32'h1);
        check("map_q0", {30'd0, bus.q0}, 32'h0);
        drive(1'b0, 2'b00, 2'd0);
        next_half();
        check("map_idle_v", {28'd0, bus.out_valid}, 32'h0);
        check("map_stale_q3", {30'd0, bus.q3}, 32'h1);

        // Backpressure on channel 3
        bus.out_ready = 4'b0111;
        drive(1'b1, 2'b00, 2'd2);
        next_half();
        check("bp_v", {28'd0, bus.out_valid}, 32'h8);
        check("bp_q3", {30'd0, bus.q3}, 32'h2);
        drive(1'b1, 2'b00, 2'd3);
        check("bp_blocked_rdy", {31'd0, bus.in_ready}, 32'h0);
        next_half();
        check("bp_hold_q3", {30'd0, bus.q3}, 32'h2);
        check("bp_hold_v", {28'd0, bus.out_valid}, 32'h8);
        drive(1'b1, 2'b11, 2'd1);
        check("bp_other_rdy", {31'd0, bus.in_ready}, 32'h1);
        next_half();
        check("bp_q0", {30'd0, bus.q0}, 32'h1);
        check("bp_v_both", {28'd0, bus.out_valid}, 32'h9);
        check("bp_q3_still", {30'd0, bus.q3}, 32'h2);
        drive(1'b1, 2'b00, 2'd3);
        bus.out_ready = 4'b1111;
        #1;
        check("bp_release_rdy", {31'd0, bus.in_ready}, 32'h1);
        next_half();
        check("bp_release_q3", {30'd0, bus.q3}, 32'h3);
        check("bp_release_v", {28'd0, bus.out_valid}, 32'h8);
        drive(1'b0, 2'b00, 2'd0);
        next_half();
        check("bp_drained_v", {28'd0, bus.out_valid}, 32'h0);

        // Streaming into channel 2
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b01, DW'(i));
            check("stream_rdy", {31'd0, bus.in_ready}, 32'h1);
            next_half();
            check("stream_q2", {30'd0, bus.q2}, 32'(i));
            check("stream_v2", {31'd0, bus.out_valid[2]}, 32'h1);
        end
        drive(1'b0, 2'b00, 2'd0);
        next_half();
        check("stream_end_v", {28'd0, bus.out_valid}, 32'h0);

        // Fill all channels, then reset asynchronously mid-cycle
        bus.out_ready = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), DW'(3 - s));
            next_half();
        end
        drive(1'b0, 2'b00, 2'd0);
        check("fill_v", {28'd0, bus.out_valid}, 32'hF);
        check("fill_q3", {30'd0, bus.q3}, 32'h3);
        check("fill_q0", {30'd0, bus.q0}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_v", {28'd0, bus.out_valid}, 32'h0);
        check("async_rst_q3", {30'd0, bus.q3}, 32'h0);
        next_half();
        rst_n = 1'b1;
        bus.out_ready = 4'b1111;
        next_half();
        check("post_rst_v0", {28'd0, bus.out_valid}, 32'h0);
        next_half();
        check("post_rst_v1", {28'd0, bus.out_valid}, 32'h0);

`ifdef DEMUX1_4_DISPATCH_CNT_EN
        check("cnt_after_rst", dlv_cnt, 32'h0);
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, 2'b10, DW'(n));
            next_half();
        end
        drive(1'b0, 2'b00, 2'd0);
        next_half();
        next_half();
        check("cnt_sat", dlv_cnt, 32'h0000FF00);

        drive(1'b1, 2'b10, 2'd1);
        next_half();
        drive(1'b0, 2'b00, 2'd0);
        cnt_clr = 1'b1;
        next_half();
        cnt_clr = 1'b0;
        check("cnt_clr_prio", dlv_cnt, 32'h0);
        drive(1'b1, 2'b10, 2'd2);
        next_half();
        drive(1'b0, 2'b00, 2'd0);
        next_half();
        check("cnt_inc_after_clr", dlv_cnt, 32'h00000100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
